dircc_node_rx_slot_writer: RTL
==============================

Name: dircc_node_rx_slot_writer

Overview:
- Receive-side stage directly upstream of the node processing memory's 16-bit second port.
- Accepts 16-bit Avalon-ST message packets from the node network interface and writes each packet into one fixed-size slot of a ring region in processing memory.
- Prepends a length header to each slot.
- Exposes a small Avalon-MM CSR so the Nios can see the slot count and release consumed slots.

Parameters:
- BASE_ADDR, 12000: 16-bit word address of slot 0 in processing memory. Must satisfy BASE_ADDR + SLOT_WORDS*NUM_SLOTS <= 15000.
- SLOT_WORDS, 64: 16-bit words per slot, header included. Power of two, 4..256.
- NUM_SLOTS, 32: slots in the ring. Power of two, 2..64.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  16  stream payload beat
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_startofpacket  in  1  first beat of packet
- in_endofpacket  in  1  last beat of packet
- mem_address  out  14  processing-memory word address
- mem_writedata  out  16  write data
- mem_byteenable  out  2  always 2'b11
- mem_chipselect  out  1  equals mem_write
- mem_write  out  1  write strobe
- mem_clken  out  1  constant 1
- csr_address  in  2  CSR word select
- csr_read  in  1  CSR read
- csr_write  in  1  CSR write
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, valid 1 cycle after csr_read
- irq  out  1  see Optional Feature

Behaviour:
- Reset values: all outputs 0 except mem_clken=1 and mem_byteenable=2'b11; head=tail=count=0; wptr=0; state IDLE; sticky flags and drop_cnt cleared.
- States:
  - IDLE: in_ready = (count != NUM_SLOTS). Beat with SOP → RECV, wptr=1, data written. Beat without SOP is discarded (accepted, no write).
  - RECV: in_ready=1. Each accepted beat is written at BASE_ADDR + head*SLOT_WORDS + wptr, then wptr increments.
    - Beat with EOP → HDR.
    - Beat arriving when wptr == SLOT_WORDS, i.e. overlength, → DROP; that beat is not written.
    - SOP seen in RECV: the packet is restarted with wptr=1 in the same slot; the malformed flag is set.
  - HDR: in_ready=0. Writes word BASE_ADDR + head*SLOT_WORDS = wptr-1, the payload beat count. Then head = head+1 (mod NUM_SLOTS), count+1, → IDLE.
  - DROP: in_ready=1. Discards beats until EOP inclusive, then → IDLE. head is not advanced. overflow sticky is set; drop_cnt is incremented, saturating at 0xFFFF.
- Write latency: an accepted beat appears on mem_write/mem_address/mem_writedata exactly one cycle later, registered. The header write occurs in the cycle after the last payload write. Max throughput is 1 beat/cycle; each packet costs one extra cycle.
- Full: count == NUM_SLOTS holds in_ready low in IDLE only. A packet in progress always completes, since its slot was reserved at SOP.
- CSR map, readdata registered:
  - 0 STATUS: [6:0] count, [8] overflow, [9] malformed. Write 1s to [9:8] to clear.
  - 1 HEAD: [5:0] head (read-only).
  - 2 TAIL: [5:0] tail. Any write releases one slot: tail+1, count-1. Ignored when count==0.
  - 3 DROPS: [15:0] drop_cnt, [16] irq_en (R/W). Writing clears drop_cnt.
- Simultaneous HDR commit and release: count unchanged, head and tail both advance.
- Pointer wrap: head and tail wrap from NUM_SLOTS-1 to 0.
- Reset mid-packet: the partial slot is abandoned and all pointers return to 0.

Optional Feature:
- Macro: DIRCC_RX_IRQ_EN.
- Defined: irq is a register, high one cycle after (count != 0) & irq_en, and low one cycle after count reaches 0 or irq_en is cleared.
- Undefined: irq is tied 0, irq_en is not implemented, and DROPS[16] reads 0.

Test Plan:
- Reset, then 3-beat packet 0x1111,0x2222,0x3333 (SOP first, EOP last) → writes 12001=0x1111, 12002=0x2222, 12003=0x3333 on consecutive cycles, then 12000=0x0003; STATUS count=1, HEAD=1.
- 33 single-beat packets with no releases → 32 slots written (last header at 12000+31*64); in_ready stays 0 on the 33rd SOP; one TAIL write → 33rd packet lands in slot 0, HEAD=1, count=32.
- 70-beat packet → words 1..63 of the slot written, no header write, HEAD unchanged, STATUS[8]=1, DROPS=1; the next packet reuses the same slot.
- HDR commit in the same cycle as a TAIL write with count=5 → count stays 5, head+1, tail+1.
- Beats without SOP while idle → accepted, no mem_write. Mid-packet SOP → restart at wptr=1, STATUS[9]=1.
- With DIRCC_RX_IRQ_EN: set irq_en, send 1 packet → irq=1 the cycle after count=1; TAIL write → irq=0. Without the macro: irq stays 0 throughout.

Source files
------------

// File: rtl/dircc_node_rx_slot_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : dircc_node_rx_slot_writer_if
// Purpose : Stream, processing-memory and CSR signals of the RX slot writer.
// Revision: 1.0
// ============================================================================
interface dircc_node_rx_slot_writer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_startofpacket;
    logic        in_endofpacket;

    logic [13:0] mem_address;
    logic [15:0] mem_writedata;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic        mem_clken;

    logic [1:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic        irq;

    // Slot-writer side: stream sink, memory writer, CSR target.
    modport slave (
        input  in_data, in_valid, in_startofpacket, in_endofpacket,
        output in_ready,
        output mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata, irq
    );

    modport master (
        output in_data, in_valid, in_startofpacket, in_endofpacket,
        input  in_ready,
        input  mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, mem_clken,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/dircc_node_rx_slot_writer.sv
`default_nettype none
// ============================================================================
// Module  : dircc_node_rx_slot_writer
// Purpose : Writes Avalon-ST packets into a ring of length-prefixed memory
//           slots; optional interrupt enabled by macro DIRCC_RX_IRQ_EN.
// Revision: 1.0
// ============================================================================
module dircc_node_rx_slot_writer #(
    parameter int BASE_ADDR  = 12000,
    parameter int SLOT_WORDS = 64,
    parameter int NUM_SLOTS  = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    dircc_node_rx_slot_writer_if.slave   bus
);

    localparam int HW     = $clog2(NUM_SLOTS);
    localparam int CW     = HW + 1;
    localparam int SW_LOG = $clog2(SLOT_WORDS);
    localparam int PW     = SW_LOG + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HDR  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   head_q, head_d;
    logic [HW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic            overflow_q, overflow_d;
    logic            malformed_q, malformed_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            mem_write_q, mem_write_d;
    logic [13:0]     mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [13:0]     w_slot_base;
    logic            w_full;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_commit;
    logic            w_release;
    logic            w_set_ovf;
    logic            w_set_mal;
    logic            w_wr_status;
    logic            w_wr_drops;
    logic            w_irq_en;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_slot_base = 14'(BASE_ADDR) + (14'(head_q) << SW_LOG);
    assign w_full      = (count_q == CW'(NUM_SLOTS));
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_release   = bus.csr_write && (bus.csr_address == 2'd2) && (count_q != '0);
    assign w_wr_status = bus.csr_write && (bus.csr_address == 2'd0);
    assign w_wr_drops  = bus.csr_write && (bus.csr_address == 2'd3);
    assign w_unused    = ^{bus.csr_writedata[31:17], bus.csr_writedata[16], bus.csr_writedata[7:0]};

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        w_in_ready  = 1'b0;
        w_commit    = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_mal   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Full only blocks new packets; the slot is reserved at SOP.
                w_in_ready = !w_full;
                if (w_accept && bus.in_startofpacket) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = w_slot_base + 14'd1;
                    mem_wdata_d = bus.in_data;
                    wptr_d      = PW'(2);
                    state_d     = bus.in_endofpacket ? S_HDR : S_RECV;
                end
            end
            S_RECV: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    if (bus.in_startofpacket) begin
                        w_set_mal   = 1'b1;
                        mem_write_d = 1'b1;
                        mem_addr_d  = w_slot_base + 14'd1;
                        mem_wdata_d = bus.in_data;
                        wptr_d      = PW'(2);
                        state_d     = bus.in_endofpacket ? S_HDR : S_RECV;
                    end else if (wptr_q == PW'(SLOT_WORDS)) begin
                        // An overlength beat that is also EOP has nothing left to discard.
                        w_set_ovf = 1'b1;
                        state_d   = bus.in_endofpacket ? S_IDLE : S_DROP;
                    end else begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = w_slot_base + 14'(wptr_q);
                        mem_wdata_d = bus.in_data;
                        wptr_d      = wptr_q + PW'(1);
                        if (bus.in_endofpacket) begin
                            state_d = S_HDR;
                        end
                    end
                end
            end
            S_HDR: begin
                mem_write_d = 1'b1;
                mem_addr_d  = w_slot_base;
                mem_wdata_d = 16'(wptr_q - PW'(1));
                w_commit    = 1'b1;
                state_d     = S_IDLE;
            end
            S_DROP: begin
                w_in_ready = 1'b1;
                if (w_accept && bus.in_endofpacket) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d = w_commit  ? head_q + HW'(1) : head_q;
        tail_d = w_release ? tail_q + HW'(1) : tail_q;
        case ({w_commit, w_release})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = w_set_ovf | (overflow_q  & ~(w_wr_status & bus.csr_writedata[8]));
        malformed_d = w_set_mal | (malformed_q & ~(w_wr_status & bus.csr_writedata[9]));

        if (w_wr_drops) begin
            drop_cnt_d = 16'd0;
        end else if (w_set_ovf && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        w_status       = 32'd0;
        w_status[6:0]  = 7'(count_q);
        w_status[8]    = overflow_q;
        w_status[9]    = malformed_q;

        rdata_d = rdata_q;
        if (bus.csr_read) begin
            case (bus.csr_address)
                2'd0:    rdata_d = w_status;
                2'd1:    rdata_d = 32'(head_q);
                2'd2:    rdata_d = 32'(tail_q);
                default: rdata_d = {15'd0, w_irq_en, drop_cnt_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            wptr_q      <= '0;
            overflow_q  <= 1'b0;
            malformed_q <= 1'b0;
            drop_cnt_q  <= 16'd0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 14'd0;
            mem_wdata_q <= 16'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            wptr_q      <= wptr_d;
            overflow_q  <= overflow_d;
            malformed_q <= malformed_d;
            drop_cnt_q  <= drop_cnt_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef DIRCC_RX_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq_en_d = w_wr_drops ? bus.csr_writedata[16] : irq_en_q;
    assign irq_d    = (count_q != '0) & irq_en_q;
    assign w_irq_en = irq_en_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    assign w_irq_en = 1'b0;
    assign bus.irq  = 1'b0;
`endif

    assign bus.in_ready       = w_in_ready;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_chipselect = mem_write_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_writedata  = mem_wdata_q;
    assign bus.mem_byteenable = 2'b11;
    assign bus.mem_clken      = 1'b1;
    assign bus.csr_readdata   = rdata_q;

endmodule
`default_nettype wire
